neural_frame_assembler: RTL and testbench

- Receive-side counterpart of the sweep serializer: consumes the per-channel sample stream (data, channel id, valid) on sys_clk and rebuilds one complete multi-channel frame per sweep.
- Completed frames are presented with a per-channel presence mask through a valid/ready handshake to downstream framing/DMA logic.
- The assembly buffer and the output buffer are separate, so a new sweep can be collected while the previous frame waits on the handshake.

---
 rtl/neural_pkg.sv | 38 +++
 rtl/neural_frame_buffer.sv | 74 +++++++
 rtl/neural_frame_assembler.sv | 220 ++++++++++++++++++++++
 tb/tb_neural_frame_assembler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : neural_pkg                                                   |
// | Description : Shared types and default dimensions for the neural frame     |
// |               assembler: assembly FSM state encoding, frame container      |
// |               and the gap-counter width helper.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package neural_pkg;

   // Default frame dimensions. frame_t is sized from these, so the
   // top-level parameters default to the same values and must match them.
   localparam int NEURAL_NUM_CHANNELS = 16;
   localparam int NEURAL_DATA_WIDTH   = 16;
   localparam int NEURAL_CH_ID_WIDTH  = 4;
   localparam int NEURAL_GAP_CYCLES   = 64;
   localparam int NEURAL_CNT_WIDTH    = 8;

   typedef enum logic [0:0] {
      ASM_IDLE    = 1'b0,
      ASM_COLLECT = 1'b1
   } asm_state_e;

   typedef logic [NEURAL_NUM_CHANNELS-1:0][NEURAL_DATA_WIDTH-1:0] frame_data_t;

   typedef struct packed {
      frame_data_t                    data;
      logic [NEURAL_NUM_CHANNELS-1:0] present;
      logic [NEURAL_CNT_WIDTH-1:0]    seq;
   } frame_t;

   // Width of a counter that must reach gap-1 (at least one bit).
   function automatic int gap_width(input int gap);
      return (gap <= 2) ? 1 : $clog2(gap);
   endfunction

endpackage
`default_nettype wire

// File: rtl/neural_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : neural_frame_buffer                                          |
// | Description : Single-entry valid/ready holding register for completed      |
// |               frames. Stamps each accepted frame with the running sequence |
// |               number and counts frames lost because the entry was full.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk          in   clock                                                 |
// |   rst          in   synchronous active-high reset                           |
// |   push         in   a frame is closing this cycle                           |
// |   push_data    in   sample data of the closing frame                        |
// |   push_present in   presence mask of the closing frame                      |
// |   ready        in   downstream takes the held frame                         |
// |   frame        out  held frame (data, presence, sequence number)            |
// |   valid        out  held frame is available                                |
// |   drop_count   out  saturating count of dropped frames                     |
// +----------------------------------------------------------------------------+
module neural_frame_buffer
   import neural_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  frame_data_t                    push_data,
   input  logic [NEURAL_NUM_CHANNELS-1:0] push_present,
   input  logic                           ready,
   output frame_t                         frame,
   output logic                           valid,
   output logic [NEURAL_CNT_WIDTH-1:0]    drop_count
);

   frame_t                      r_frame;
   logic                        r_valid;
   logic [NEURAL_CNT_WIDTH-1:0] r_seq;
   logic [NEURAL_CNT_WIDTH-1:0] r_drop;

   logic w_pop;
   logic w_space;

   assign w_pop   = r_valid && ready;
   // A frame popped this cycle frees the entry for a frame closing this cycle.
   assign w_space = !r_valid || w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= '0;
         r_valid <= 1'b0;
         r_seq   <= '0;
         r_drop  <= '0;
      end else begin
         if (push) begin
            if (w_space) begin
               r_frame.data    <= push_data;
               r_frame.present <= push_present;
               r_frame.seq     <= r_seq;
               r_seq           <= r_seq + NEURAL_CNT_WIDTH'(1);
               r_valid         <= 1'b1;
            end else if (r_drop != '1) begin
               r_drop <= r_drop + NEURAL_CNT_WIDTH'(1);
            end
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign frame      = r_frame;
   assign valid      = r_valid;
   assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: rtl/neural_frame_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : neural_frame_assembler                                       |
// | Description : Rebuilds one multi-channel frame per sweep from a serial     |
// |               per-channel sample stream. Frames close on channel wrap,     |
// |               on completion against channel_mask, or after an idle gap,    |
// |               and are handed to a single-entry valid/ready output buffer.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   sys_clk           in   clock                                            |
// |   rst               in   synchronous active-high reset                    |
// |   channel_mask      in   expected channels (quasi-static)                 |
// |   adc_data_in       in   sample data                                      |
// |   adc_channel_in    in   sample channel id                                |
// |   adc_valid_in      in   sample qualifier                                 |
// |   frame_data_out    out  assembled samples, one per channel               |
// |   frame_present_out out  channels received in this frame                 |
// |   frame_seq_out     out  frame sequence number                           |
// |   frame_valid_out   out  frame available                                 |
// |   frame_ready_in    in   downstream accepts the frame                     |
// |   drop_count_out    out  saturating count of dropped frames              |
// |   err_unexpected_ch out  one-cycle pulse for a rejected sample            |
// +----------------------------------------------------------------------------+
module neural_frame_assembler
   import neural_pkg::*;
#(
   parameter int NUM_CHANNELS = NEURAL_NUM_CHANNELS,
   parameter int DATA_WIDTH   = NEURAL_DATA_WIDTH,
   parameter int CH_ID_WIDTH  = NEURAL_CH_ID_WIDTH,
   parameter int GAP_CYCLES   = NEURAL_GAP_CYCLES,
   parameter int CNT_WIDTH    = NEURAL_CNT_WIDTH
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic [NUM_CHANNELS-1:0] channel_mask,
   input  logic [DATA_WIDTH-1:0]   adc_data_in,
   input  logic [CH_ID_WIDTH-1:0]  adc_channel_in,
   input  logic                    adc_valid_in,
   output logic [DATA_WIDTH-1:0]   frame_data_out [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0] frame_present_out,
   output logic [CNT_WIDTH-1:0]    frame_seq_out,
   output logic                    frame_valid_out,
   input  logic                    frame_ready_in,
   output logic [CNT_WIDTH-1:0]    drop_count_out,
   output logic                    err_unexpected_ch
);

   localparam int                 GAP_W      = gap_width(GAP_CYCLES);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [CH_ID_WIDTH:0] NUM_CH_EXT = (CH_ID_WIDTH + 1)'(NUM_CHANNELS);

   // Assembly state
   asm_state_e                                r_state;
   asm_state_e                                w_state_next;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   r_asm_data;
   logic [NUM_CHANNELS-1:0]                   r_present;
   logic [CH_ID_WIDTH-1:0]                    r_last_id;
   logic [GAP_W-1:0]                          r_gap;
   logic                                      r_err;

   // Per-cycle decode
   logic                                      w_accept;
   logic                                      w_wrap;
   logic [NUM_CHANNELS-1:0]                   w_sel;
   logic [NUM_CHANNELS-1:0]                   w_present_after;
   logic                                      w_write;
   logic                                      w_close;
   logic                                      w_gap_inc;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   w_close_data;
   logic [NUM_CHANNELS-1:0]                   w_close_present;

   // Output buffer
   frame_t                                    buf_frame;
   logic                                      buf_valid;
   logic [CNT_WIDTH-1:0]                      buf_drop;

   // ------------------------------------------------------------------
   // Sample qualification
   // ------------------------------------------------------------------
   assign w_accept = adc_valid_in
                  && ({1'b0, adc_channel_in} < NUM_CH_EXT)
                  && channel_mask[adc_channel_in];

   // A sample at or below the last stored id means the source started a
   // new sweep; only meaningful while a frame is open.
   assign w_wrap = w_accept && (adc_channel_in <= r_last_id);

   always_comb begin
      w_sel = '0;
      if (w_accept) begin
         w_sel[adc_channel_in] = 1'b1;
      end
   end

   assign w_present_after = r_present | w_sel;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= ASM_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and control
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_close      = 1'b0;
      w_gap_inc    = 1'b0;
      case (r_state)
         ASM_IDLE: begin
            if (w_accept) begin
               w_write      = 1'b1;
               w_state_next = ASM_COLLECT;
            end
         end
         ASM_COLLECT: begin
            if (w_wrap) begin
               // Close the open frame; this sample starts the next one.
               w_close = 1'b1;
               w_write = 1'b1;
            end else if (w_present_after == channel_mask) begin
               // Also fires with no sample if the mask shrinks onto the
               // channels already collected.
               w_close      = 1'b1;
               w_write      = w_accept;
               w_state_next = ASM_IDLE;
            end else if (!w_accept && (r_gap == GAP_LAST)) begin
               w_close      = 1'b1;
               w_state_next = ASM_IDLE;
            end else if (w_accept) begin
               w_write = 1'b1;
            end else begin
               w_gap_inc = 1'b1;
            end
         end
         default: begin
            w_state_next = ASM_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Closing-frame snapshot: a completing sample is part of the frame it
   // completes, a wrapping sample is not.
   // ------------------------------------------------------------------
   always_comb begin
      w_close_data = r_asm_data;
      if (w_accept && !w_wrap) begin
         w_close_data[adc_channel_in] = adc_data_in;
      end
   end

   assign w_close_present = w_wrap ? r_present : w_present_after;

   // ------------------------------------------------------------------
   // Assembly buffer
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_asm_data <= '0;
         r_present  <= '0;
         r_last_id  <= '0;
         r_gap      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= adc_valid_in && !w_accept;

         // Data of absent channels is never cleared; it simply keeps the
         // last value written.
         if (w_write) begin
            r_asm_data[adc_channel_in] <= adc_data_in;
            r_last_id                  <= adc_channel_in;
            r_gap                      <= '0;
         end else if (w_gap_inc && (r_gap != '1)) begin
            r_gap <= r_gap + GAP_W'(1);
         end

         if (w_close) begin
            r_present <= w_wrap ? w_sel : '0;
         end else if (w_write) begin
            r_present <= w_present_after;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output buffer
   // ------------------------------------------------------------------
   neural_frame_buffer u_frame_buffer (
      .clk          (sys_clk),
      .rst          (rst),
      .push         (w_close),
      .push_data    (w_close_data),
      .push_present (w_close_present),
      .ready        (frame_ready_in),
      .frame        (buf_frame),
      .valid        (buf_valid),
      .drop_count   (buf_drop)
   );

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_data_out
      assign frame_data_out[gi] = buf_frame.data[gi];
   end

   assign frame_present_out = buf_frame.present;
   assign frame_seq_out     = buf_frame.seq;
   assign frame_valid_out   = buf_valid;
   assign drop_count_out    = buf_drop;
   assign err_unexpected_ch = r_err;

endmodule
`default_nettype wire

// File: tb/tb_neural_frame_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_neural_frame_assembler                                    |
// | Description : Directed and randomized bench for neural_frame_assembler     |
// |               with a frame-level reference model.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_neural_frame_assembler;

   localparam int NC  = 16;
   localparam int DW  = 16;
   localparam int IW  = 4;
   localparam int GAP = 64;
   localparam int CW  = 8;

   logic          sys_clk = 1'b0;
   logic          rst;
   logic [NC-1:0] channel_mask;
   logic [DW-1:0] adc_data_in;
   logic [IW-1:0] adc_channel_in;
   logic          adc_valid_in;
   logic [DW-1:0] frame_data_out [NC];
   logic [NC-1:0] frame_present_out;
   logic [CW-1:0] frame_seq_out;
   logic          frame_valid_out;
   logic          frame_ready_in;
   logic [CW-1:0] drop_count_out;
   logic          err_unexpected_ch;

   int n_tests = 0;
   int n_fail  = 0;

   neural_frame_assembler #(
      .NUM_CHANNELS (NC),
      .DATA_WIDTH   (DW),
      .CH_ID_WIDTH  (IW),
      .GAP_CYCLES   (GAP),
      .CNT_WIDTH    (CW)
   ) dut (
      .sys_clk           (sys_clk),
      .rst               (rst),
      .channel_mask      (channel_mask),
      .adc_data_in       (adc_data_in),
      .adc_channel_in    (adc_channel_in),
      .adc_valid_in      (adc_valid_in),
      .frame_data_out    (frame_data_out),
      .frame_present_out (frame_present_out),
      .frame_seq_out     (frame_seq_out),
      .frame_valid_out   (frame_valid_out),
      .frame_ready_in    (frame_ready_in),
      .drop_count_out    (drop_count_out),
      .err_unexpected_ch (err_unexpected_ch)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: open frame as a presence set plus sample store,
   // output side as a one-slot holding area.
   // ------------------------------------------------------------------
   bit            m_open;
   logic [NC-1:0] m_present;
   logic [DW-1:0] m_asm [NC];
   int            m_last;
   int            m_idle;
   bit            m_ovalid;
   logic [DW-1:0] m_odata [NC];
   logic [NC-1:0] m_opresent;
   int            m_oseq;
   int            m_seq;
   int            m_drop;
   bit            m_err;

   task automatic model_step();
      bit            acc, pop, close;
      logic [DW-1:0] snap [NC];
      logic [NC-1:0] snap_p;
      int            ch;
      if (rst) begin
         m_open = 0; m_present = '0; m_last = 0; m_idle = 0;
         m_ovalid = 0; m_opresent = '0; m_oseq = 0; m_seq = 0; m_drop = 0; m_err = 0;
         for (int i = 0; i < NC; i++) begin
            m_asm[i] = '0;
            m_odata[i] = '0;
         end
         return;
      end
      ch     = int'(adc_channel_in);
      acc    = adc_valid_in && (ch < NC) && channel_mask[ch];
      m_err  = adc_valid_in && !acc;
      pop    = m_ovalid && frame_ready_in;
      close  = 0;
      snap   = m_asm;
      snap_p = m_present;
      if (!m_open) begin
         if (acc) begin
            m_asm[ch] = adc_data_in;
            m_present = '0; m_present[ch] = 1'b1;
            m_last = ch; m_idle = 0; m_open = 1;
         end
      end else if (acc && ch <= m_last) begin
         close = 1;
         m_asm[ch] = adc_data_in;
         m_present = '0; m_present[ch] = 1'b1;
         m_last = ch; m_idle = 0;
      end else begin
         if (acc) begin
            m_asm[ch] = adc_data_in;
            m_present[ch] = 1'b1;
            m_last = ch; m_idle = 0;
         end else begin
            m_idle++;
         end
         if (m_present == channel_mask) begin
            close = 1; snap = m_asm; snap_p = m_present;
            m_present = '0; m_open = 0;
         end else if (m_idle >= GAP) begin
            close = 1; snap = m_asm; snap_p = m_present;
            m_present = '0; m_open = 0;
         end
      end
      if (close) begin
         if (!m_ovalid || pop) begin
            m_odata = snap; m_opresent = snap_p; m_oseq = m_seq;
            m_seq = (m_seq + 1) % 256; m_ovalid = 1;
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end else if (pop) begin
         m_ovalid = 0;
      end
   endtask

   // Compare process: inputs change only just after a falling edge, so at
   // the falling edge they still hold what the last rising edge sampled.
   initial begin
      forever begin
         @(negedge sys_clk);
         model_step();
         check("valid", frame_valid_out, m_ovalid);
         check("drop", drop_count_out, m_drop);
         check("err", err_unexpected_ch, m_err);
         if (m_ovalid) begin
            check("present", frame_present_out, m_opresent);
            check("seq", frame_seq_out, m_oseq);
            for (int i = 0; i < NC; i++) begin
               check($sformatf("data[%0d]", i), frame_data_out[i], m_odata[i]);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic send(input int ch, input int d);
      adc_valid_in   = 1'b1;
      adc_channel_in = IW'(ch);
      adc_data_in    = DW'(d);
      tick();
      adc_valid_in   = 1'b0;
   endtask

   task automatic idle(input int n);
      adc_valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pop_one();
      frame_ready_in = 1'b1;
      idle(1);
      frame_ready_in = 1'b0;
   endtask

   initial begin
      int nxt;
      rst = 1'b1; channel_mask = 16'hFFFF; adc_data_in = '0;
      adc_channel_in = '0; adc_valid_in = 1'b0; frame_ready_in = 1'b0;
      idle(2);
      rst = 1'b0;

      // Reset state
      check("rst_valid", frame_valid_out, 1'b0);
      check("rst_present", frame_present_out, 16'h0000);
      check("rst_seq", frame_seq_out, 8'h00);
      check("rst_drop", drop_count_out, 8'h00);
      check("rst_data3", frame_data_out[3], 16'h0000);

      // Full sweep
      for (int i = 0; i < 16; i++) send(i, 16'h1000 + i);
      check("full_valid", frame_valid_out, 1'b1);
      check("full_present", frame_present_out, 16'hFFFF);
      check("full_seq", frame_seq_out, 8'd0);
      check("full_data5", frame_data_out[5], 16'h1005);
      pop_one();
      check("full_popped", frame_valid_out, 1'b0);

      // Sparse mask with a rejected id
      channel_mask = 16'h00F0;
      send(4, 16'h4004); send(5, 16'h4005);
      send(2, 16'hBEEF);
      check("sparse_err", err_unexpected_ch, 1'b1);
      send(6, 16'h4006);
      check("sparse_err_clear", err_unexpected_ch, 1'b0);
      send(7, 16'h4007);
      check("sparse_valid", frame_valid_out, 1'b1);
      check("sparse_present", frame_present_out, 16'h00F0);
      check("sparse_seq", frame_seq_out, 8'd1);
      check("sparse_data2", frame_data_out[2], 16'h1002);
      check("sparse_data6", frame_data_out[6], 16'h4006);
      pop_one();

      // Wrap close, then resume the same frame after a short gap
      channel_mask = 16'hFFFF;
      for (int i = 0; i < 10; i++) send(i, 16'h2000 + i);
      send(0, 16'h2100);
      check("wrap_valid", frame_valid_out, 1'b1);
      check("wrap_present", frame_present_out, 16'h03FF);
      check("wrap_seq", frame_seq_out, 8'd2);
      check("wrap_data0", frame_data_out[0], 16'h2000);
      pop_one();
      idle(14);
      for (int i = 1; i < 16; i++) send(i, 16'h2200 + i);
      check("wrap2_present", frame_present_out, 16'hFFFF);
      check("wrap2_seq", frame_seq_out, 8'd3);
      check("wrap2_data0", frame_data_out[0], 16'h2100);
      pop_one();

      // Timeout
      for (int i = 0; i < 4; i++) send(i, 16'h5000 + i);
      for (int k = 1; k <= GAP; k++) begin
         idle(1);
         if (k == GAP - 1) check("tmo_early", frame_valid_out, 1'b0);
      end
      check("tmo_valid", frame_valid_out, 1'b1);
      check("tmo_present", frame_present_out, 16'h000F);
      check("tmo_seq", frame_seq_out, 8'd4);
      pop_one();

      // Backpressure and drops
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 16; i++) send(i, 16'h6000 + s * 16 + i);
      check("bp_valid", frame_valid_out, 1'b1);
      check("bp_seq", frame_seq_out, 8'd5);
      check("bp_data0", frame_data_out[0], 16'h6000);
      check("bp_drop", drop_count_out, 8'd2);
      pop_one();
      check("bp_released", frame_valid_out, 1'b0);

      // Reset mid-frame
      for (int i = 0; i < 8; i++) send(i, 16'h7000 + i);
      rst = 1'b1; idle(1); rst = 1'b0;
      for (int i = 0; i < 16; i++) send(i, 16'h7100 + i);
      check("rstm_valid", frame_valid_out, 1'b1);
      check("rstm_seq", frame_seq_out, 8'd0);
      check("rstm_present", frame_present_out, 16'hFFFF);
      check("rstm_drop", drop_count_out, 8'd0);
      check("rstm_data7", frame_data_out[7], 16'h7107);
      pop_one();

      // Single-channel mask: one frame per sample, sequence wraps past 255
      channel_mask = 16'h0001;
      frame_ready_in = 1'b1;
      for (int n = 0; n < 300; n++) send(0, $urandom_range(16'hFFFF));
      check("seqwrap_a", frame_seq_out, 8'd43);
      idle(1);
      check("seqwrap_b", frame_seq_out, 8'd44);
      idle(1);
      check("seqwrap_popped", frame_valid_out, 1'b0);
      frame_ready_in = 1'b0;

      // Drop counter saturation
      for (int n = 0; n < 300; n++) send(0, n);
      check("drop_sat", drop_count_out, 8'hFF);
      rst = 1'b1; idle(1); rst = 1'b0;
      check("drop_cleared", drop_count_out, 8'h00);

      // Randomized traffic
      channel_mask = 16'hFFFF;
      nxt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(199) == 0) begin
            case ($urandom_range(3))
               0:       channel_mask = 16'hFFFF;
               1:       channel_mask = 16'h0F0F;
               2:       channel_mask = 16'h0007;
               default: channel_mask = NC'($urandom);
            endcase
         end
         frame_ready_in = ($urandom_range(3) != 0);
         if ($urandom_range(149) == 0) begin
            idle(GAP + $urandom_range(4));
         end else if ($urandom_range(999) == 0) begin
            rst = 1'b1; idle(1); rst = 1'b0;
         end else begin
            if ($urandom_range(4) == 0) nxt = $urandom_range(NC - 1);
            adc_valid_in   = ($urandom_range(2) != 0);
            adc_channel_in = IW'(nxt);
            adc_data_in    = DW'($urandom);
            nxt = (nxt + 1) % NC;
            tick();
            adc_valid_in = 1'b0;
         end
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
